// File: rtl/hex_word_scroller_if.sv
// Character-entry and display bus between the mux stage, the scroller and the board.
interface hex_word_scroller_if;
  logic [2:0] char_in;
  logic       load;
  logic       run;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic [6:0] HEX6;
  logic [6:0] HEX7;
  logic       scrolling;
  logic [3:0] char_count;

  modport master (
    output char_in, load, run,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, scrolling, char_count
  );

  modport slave (
    input  char_in, load, run,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7, scrolling, char_count
  );
endinterface

// File: rtl/hex_word_scroller.sv
// Eight-character word buffer shown on eight active-low 7-segment digits,
// loaded one character per load edge and rotated leftward while run is high.
module hex_word_scroller #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  hex_word_scroller_if.slave bus
);
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned CHAR_W     = 3;
  localparam int unsigned BUF_W      = NUM_DIGITS * CHAR_W;
  localparam int unsigned CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]       COUNT_SAT = 4'(NUM_DIGITS);

  typedef enum logic {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               tick_c;
  logic               load_q;
  logic               load_rise_c;
  logic [BUF_W-1:0]   buffer;      // entry i lives at [3*i +: 3]; entry 0 drives HEX0
  logic [3:0]         count_q;
  logic               scrolling_q;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one character code.
  function automatic logic [6:0] seg(input logic [2:0] code);
    logic [6:0] s;
    s = 7'h7F;
    if (!code[2]) begin
      case (code[1:0])
        2'b00:   s = 7'h09;
        2'b01:   s = 7'h06;
        2'b10:   s = 7'h47;
        default: s = 7'h40;
      endcase
    end
    return s;
  endfunction

  assign load_rise_c = bus.load & ~load_q;

  // Next state, tick-counter update and tick strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tick_c     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bus.run) state_next = SCROLL;
      end
      SCROLL: begin
        tick_c = (cnt == CNT_MAX);
        if (!bus.run) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (tick_c) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // State register, tick counter and registered scrolling flag.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      scrolling_q <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      scrolling_q <= (state_next == SCROLL);
    end
  end

  // Load edge detect; load_q presets high so a held key cannot load out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) load_q <= 1'b1;
    else       load_q <= bus.load;
  end

  // Character buffer: a load shifts in the new code and beats a same-cycle rotation.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      buffer <= {NUM_DIGITS{3'b111}};
    end else if (load_rise_c) begin
      buffer <= {buffer[BUF_W-CHAR_W-1:0], bus.char_in};
    end else if (tick_c) begin
      buffer <= {buffer[BUF_W-CHAR_W-1:0], buffer[BUF_W-1 -: CHAR_W]};
    end
  end

  // Loaded-character counter, saturating at the buffer depth.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_rise_c && (count_q != COUNT_SAT)) begin
      count_q <= count_q + 4'd1;
    end
  end

  // Registered segment decode, one cycle behind the buffer.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bus.HEX0 <= 7'h7F;
      bus.HEX1 <= 7'h7F;
      bus.HEX2 <= 7'h7F;
      bus.HEX3 <= 7'h7F;
      bus.HEX4 <= 7'h7F;
      bus.HEX5 <= 7'h7F;
      bus.HEX6 <= 7'h7F;
      bus.HEX7 <= 7'h7F;
    end else begin
      bus.HEX0 <= seg(buffer[0*CHAR_W +: CHAR_W]);
      bus.HEX1 <= seg(buffer[1*CHAR_W +: CHAR_W]);
      bus.HEX2 <= seg(buffer[2*CHAR_W +: CHAR_W]);
      bus.HEX3 <= seg(buffer[3*CHAR_W +: CHAR_W]);
      bus.HEX4 <= seg(buffer[4*CHAR_W +: CHAR_W]);
      bus.HEX5 <= seg(buffer[5*CHAR_W +: CHAR_W]);
      bus.HEX6 <= seg(buffer[6*CHAR_W +: CHAR_W]);
      bus.HEX7 <= seg(buffer[7*CHAR_W +: CHAR_W]);
    end
  end

  assign bus.scrolling  = scrolling_q;
  assign bus.char_count = count_q;
endmodule

// File: tb/tb_hex_word_scroller.sv
// Scoreboard bench for hex_word_scroller: a character-level word model predicts the
// display every cycle, a monitor compares it against the DUT on the falling edge.
module tb_hex_word_scroller;
  localparam int T = 4;

  typedef struct packed {
    logic [55:0] hex;   // {HEX7,...,HEX0}
    logic        scr;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  hex_word_scroller_if bus ();

  hex_word_scroller #(.TICK_DIV(T)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  // Model state: the word as characters, display as last shown, scroll progress.
  byte  m_word [8];     // index 0 = rightmost digit; ' ' is blank
  byte  m_shown [8];
  bit   m_started = 0;
  bit   m_prev;
  bit   m_scroll;
  int   m_since;        // edges elapsed since SCROLL was entered
  int   m_count;

  function automatic byte char_of(input logic [2:0] code);
    case (code)
      3'b000:  return "H";
      3'b001:  return "E";
      3'b010:  return "L";
      3'b011:  return "O";
      default: return " ";
    endcase
  endfunction

  function automatic logic [6:0] glyph(input byte ch);
    case (ch)
      "H":     return 7'h09;
      "E":     return 7'h06;
      "L":     return 7'h47;
      "O":     return 7'h40;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model evaluated on every rising edge with the inputs the DUT sees.
  always @(posedge clk) begin
    byte old_word [8];
    bit  rise;
    bit  rot;
    exp_t e;
    if (reset) begin
      m_started = 1;
      for (int i = 0; i < 8; i++) begin
        m_word[i]  = " ";
        m_shown[i] = " ";
      end
      m_prev   = 1;
      m_scroll = 0;
      m_since  = 0;
      m_count  = 0;
    end else if (m_started) begin
      rise = bus.load && !m_prev;
      m_prev = bus.load;
      rot = 0;
      if (m_scroll) begin
        m_since = m_since + 1;
        rot = (m_since % T) == 0;
      end
      for (int i = 0; i < 8; i++) begin
        old_word[i] = m_word[i];
        m_shown[i]  = m_word[i];
      end
      if (rise) begin
        for (int i = 7; i > 0; i--) m_word[i] = old_word[i-1];
        m_word[0] = char_of(bus.char_in);
        if (m_count < 8) m_count = m_count + 1;
      end else if (rot) begin
        for (int i = 0; i < 8; i++) m_word[i] = old_word[(i + 7) % 8];
      end
      if (m_scroll && !bus.run) begin
        m_scroll = 0;
      end else if (!m_scroll && bus.run) begin
        m_scroll = 1;
        m_since  = 0;
      end
    end
    if (m_started) begin
      for (int i = 0; i < 8; i++) e.hex[i*7 +: 7] = glyph(m_shown[i]);
      e.scr = m_scroll;
      e.cnt = 4'(m_count);
      sb_q.push_back(e);
    end
  end

  // Monitor: pop one expectation per cycle and compare against the DUT.
  always @(negedge clk) begin
    exp_t e;
    logic [55:0] act_hex;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act_hex = {bus.HEX7, bus.HEX6, bus.HEX5, bus.HEX4,
                 bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
      n_cmp++;
      if (act_hex !== e.hex) begin
        n_bad++;
        $display("FAIL hex @%0t: got %h expected %h", $time, act_hex, e.hex);
      end
      n_cmp++;
      if (bus.scrolling !== e.scr) begin
        n_bad++;
        $display("FAIL scrolling @%0t: got %b expected %b", $time, bus.scrolling, e.scr);
      end
      n_cmp++;
      if (bus.char_count !== e.cnt) begin
        n_bad++;
        $display("FAIL char_count @%0t: got %0d expected %0d", $time, bus.char_count, e.cnt);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_char(input logic [2:0] code);
    bus.char_in = code;
    bus.load    = 1'b1;
    step(1);
    bus.load    = 1'b0;
    bus.char_in = 3'($urandom);
    step(1);
  endtask

  initial begin
    bit found;
    reset       = 1'b1;
    bus.load    = 1'b1;
    bus.run     = 1'b0;
    bus.char_in = 3'b000;
    step(2);

    // Load held high across reset release gives no capture.
    reset = 1'b0;
    step(5);
    bus.load = 1'b0;
    step(2);

    // HELLO loaded statically, then left alone.
    load_char(3'd0);
    load_char(3'd1);
    load_char(3'd2);
    load_char(3'd2);
    load_char(3'd3);
    step(100);

    // Scroll a full revolution and a bit.
    bus.run = 1'b1;
    step(40);

    // Load landing on a tick cycle.
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_scroll && ((m_since + 1) % T) == 0) begin
        found = 1;
        load_char(3'b000);
      end else begin
        step(1);
      end
    end
    if (!found) begin
      n_bad++;
      $display("FAIL tick_align: got no tick slot expected one within 20 cycles");
    end
    step(12);

    // Overfill the buffer while static.
    bus.run = 1'b0;
    step(3);
    for (int k = 0; k < 10; k++) load_char(3'($urandom_range(0, 4)));
    step(4);

    // Reset mid-scroll with the counter at 2, run held high.
    bus.run = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_scroll && m_since > 0 && (m_since % T) == 2) found = 1;
      else step(1);
    end
    if (!found) begin
      n_bad++;
      $display("FAIL reset_align: got no count-2 slot expected one within 20 cycles");
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(12);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0)  bus.load = ~bus.load;
      if ($urandom_range(0, 49) == 0) bus.run  = ~bus.run;
      bus.char_in = 3'($urandom);
      step(1);
    end
    reset = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
